// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S slave receiver: default sizes, channel
// encoding and receiver state encoding.
package i2s_rx_pkg;

  localparam int AUDIO_DW_DEFAULT    = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    UNSYNC = 1'b0,
    RECV   = 1'b1
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// N-stage synchroniser for an asynchronous pad input, with a registered
// rising-edge pulse of the synchronised level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              q_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain  <= '0;
      q_prev <= 1'b0;
      rise   <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], d};
      q_prev <= chain[STAGES-1];
      rise   <= chain[STAGES-1] & ~q_prev;
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sck/ws/sd and deserialises MSB-first words.
// Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay).
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int AUDIO_DW    = AUDIO_DW_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sck_i,
  input  logic                ws_i,
  input  logic                sd_i,
  output logic [AUDIO_DW-1:0] l_data_o,
  output logic [AUDIO_DW-1:0] r_data_o,
  output logic                l_valid_o,
  output logic                r_valid_o,
  output logic                synced_o,
  output logic                short_err_o
);

  localparam int CNT_W = $clog2(AUDIO_DW + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(AUDIO_DW);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(AUDIO_DW);
`else
  // The transition bit still belongs to the ending word, so one fewer is enough.
  localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(AUDIO_DW - 1);
`endif

  logic sck_rise, ws_s, sd_s;
  logic sck_level_unused, ws_rise_unused, sd_rise_unused;

  rx_state_e state, state_next;
  logic                ws_d, ws_seen, ws_edge;
  logic [CNT_W-1:0]    cnt, cnt_inc, fresh_cnt;
  logic [AUDIO_DW-1:0] shreg, word_shift, commit_word, fresh_word;
  logic                commit_short;
  logic                start_word, shift_en, commit;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d(sck_i), .q(sck_level_unused), .rise(sck_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
    .clk_i(clk_i), .rst_i(rst_i), .d(ws_i), .q(ws_s), .rise(ws_rise_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk_i(clk_i), .rst_i(rst_i), .d(sd_i), .q(sd_s), .rise(sd_rise_unused)
  );

  assign ws_edge = sck_rise & ws_seen & (ws_s != ws_d);
  assign cnt_inc = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    word_shift = shreg;
    for (int i = 0; i < AUDIO_DW; i++) begin
      if (cnt == CNT_W'(AUDIO_DW - 1 - i)) word_shift[i] = sd_s;
    end
  end

  always_comb begin
    fresh_word = '0;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    commit_word = shreg;
    fresh_word[AUDIO_DW-1] = sd_s;
    fresh_cnt = CNT_W'(1);
`else
    commit_word = word_shift;
    fresh_cnt = '0;
`endif
    commit_short = (cnt < SHORT_LIM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= UNSYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      UNSYNC:  if (ws_edge) state_next = RECV;
      RECV:    state_next = RECV;
      default: state_next = UNSYNC;
    endcase
  end

  always_comb begin
    start_word = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    synced_o   = 1'b0;
    case (state)
      UNSYNC: start_word = ws_edge;
      RECV: begin
        shift_en = sck_rise & ~ws_edge;
        commit   = ws_edge;
        synced_o = 1'b1;
      end
      default: ;
    endcase
  end

  // ws_d only becomes meaningful after the first sck rise, so a constant ws never commits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ws_d        <= 1'b0;
      ws_seen     <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      l_data_o    <= '0;
      r_data_o    <= '0;
      l_valid_o   <= 1'b0;
      r_valid_o   <= 1'b0;
      short_err_o <= 1'b0;
    end else begin
      l_valid_o   <= 1'b0;
      r_valid_o   <= 1'b0;
      short_err_o <= 1'b0;
      if (sck_rise) begin
        ws_d    <= ws_s;
        ws_seen <= 1'b1;
      end
      if (start_word || commit) begin
        shreg <= fresh_word;
        cnt   <= fresh_cnt;
      end else if (shift_en) begin
        shreg <= word_shift;
        cnt   <= cnt_inc;
      end
      if (commit) begin
        if (ws_d == CH_LEFT) begin
          l_data_o  <= commit_word;
          l_valid_o <= 1'b1;
        end
        if (ws_d == CH_RIGHT) begin
          r_data_o  <= commit_word;
          r_valid_o <= 1'b1;
        end
        short_err_o <= commit_short;
      end
    end
  end

endmodule
